// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with load, wrap/saturate and terminal-count pulse; all outputs registered.
// Optional self-check output gray_err is built only when GRAY_CHECK_EN is defined.
module gray_counter_param #(
  parameter int                 WIDTH     = 5,
  parameter int                 SATURATE  = 0,
  parameter logic [WIDTH-1:0]   INIT_GRAY = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_output,
  output logic [WIDTH-1:0] bin_output,
  output logic             tc,
  output logic             sat
`ifdef GRAY_CHECK_EN
  ,
  output logic             gray_err
`endif
);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  localparam bit               SAT_MODE = (SATURATE != 0);
  localparam logic [WIDTH-1:0] MAX_BIN  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] INIT_BIN = gray2bin(INIT_GRAY);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;

  // In saturate mode tc marks arrival at a terminal value, never a hold on it.
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    sat_d = sat_q;
    if (load) begin
      bin_d = gray2bin(load_gray);
      sat_d = SAT_MODE && ((bin_d == MAX_BIN) || (bin_d == ZERO));
    end else if (enable) begin
      if (up_dn) begin
        if (bin_q == MAX_BIN) begin
          if (SAT_MODE) begin
            sat_d = 1'b1;
          end else begin
            bin_d = ZERO;
            tc_d  = 1'b1;
          end
        end else begin
          bin_d = bin_q + ONE;
          tc_d  = SAT_MODE && (bin_d == MAX_BIN);
          sat_d = tc_d;
        end
      end else begin
        if (bin_q == ZERO) begin
          if (SAT_MODE) begin
            sat_d = 1'b1;
          end else begin
            bin_d = MAX_BIN;
            tc_d  = 1'b1;
          end
        end else begin
          bin_d = bin_q - ONE;
          tc_d  = SAT_MODE && (bin_d == ZERO);
          sat_d = tc_d;
        end
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      tc_q   <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
      sat_q  <= sat_d;
    end
  end

  assign gray_output = gray_q;
  assign bin_output  = bin_q;
  assign tc          = tc_q;
  assign sat         = sat_q;

`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] prev_q;
  logic             upd_q, sticky_q, err_q;
  logic             multi_bit, rule_viol;

  // upd_q: the value now in gray_q came from a counting edge, not load or reset.
  always_comb begin
    multi_bit = upd_q && ($countones(gray_q ^ prev_q) > 1);
    rule_viol = (!SAT_MODE && sat_q) || (tc_q && (!upd_q || (gray_q == prev_q)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= INIT_GRAY;
      upd_q    <= 1'b0;
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= gray_q;
      upd_q    <= enable && !load;
      sticky_q <= sticky_q || rule_viol;
      err_q    <= multi_bit || rule_viol || sticky_q;
    end
  end

  assign gray_err = err_q;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench: three counters (5-bit wrap, 5-bit saturate, 8-bit wrap) share stimulus.
module tb_gray_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0, enable = 1'b0, up_dn = 1'b0, load = 1'b0;
  logic [7:0] load_gray = '0;

  localparam logic [4:0] IG0 = 5'b00000;
  localparam logic [4:0] IG1 = 5'b00110;
  localparam logic [7:0] IG2 = 8'h2D;

  logic [4:0] g0, b0, g1, b1;
  logic [7:0] g2, b2;
  logic       t0, s0, t1, s1, t2, s2;
`ifdef GRAY_CHECK_EN
  logic       e0, e1, e2;
`endif

  gray_counter_param #(.WIDTH(5), .SATURATE(0), .INIT_GRAY(IG0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_gray(load_gray[4:0]), .gray_output(g0), .bin_output(b0), .tc(t0), .sat(s0)
`ifdef GRAY_CHECK_EN
    , .gray_err(e0)
`endif
  );
  gray_counter_param #(.WIDTH(5), .SATURATE(1), .INIT_GRAY(IG1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_gray(load_gray[4:0]), .gray_output(g1), .bin_output(b1), .tc(t1), .sat(s1)
`ifdef GRAY_CHECK_EN
    , .gray_err(e1)
`endif
  );
  gray_counter_param #(.WIDTH(8), .SATURATE(0), .INIT_GRAY(IG2)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_gray(load_gray), .gray_output(g2), .bin_output(b2), .tc(t2), .sat(s2)
`ifdef GRAY_CHECK_EN
    , .gray_err(e2)
`endif
  );

  typedef struct packed {
    logic [2:0][7:0] g;
    logic [2:0][7:0] b;
    logic [2:0]      t;
    logic [2:0]      s;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;

  // Reference model: plain integer count value per counter.
  int mv[3];
  bit ms[3];
  bit mt[3];
  int mw[3]   = '{5, 5, 8};
  bit msat[3] = '{1'b0, 1'b1, 1'b0};
  int mig[3];

  // Gray-to-binary by searching the code table rather than bitwise XOR folding.
  function automatic int g2b(int w, int g);
    for (int n = 0; n < (1 << w); n++)
      if ((n ^ (n >> 1)) == g) return n;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = g2b(mw[k], mig[k]);
      ms[k] = 1'b0;
      mt[k] = 1'b0;
    end
  endtask

  task automatic model_step(bit en, bit ud, bit ld, int lg);
    for (int k = 0; k < 3; k++) begin
      int mx;
      mx = (1 << mw[k]) - 1;
      mt[k] = 1'b0;
      if (ld) begin
        mv[k] = g2b(mw[k], lg & mx);
        ms[k] = msat[k] && (mv[k] == mx || mv[k] == 0);
      end else if (en) begin
        int tgt;
        tgt = ud ? mx : 0;
        if (mv[k] == tgt) begin
          if (msat[k]) ms[k] = 1'b1;
          else begin
            mv[k] = ud ? 0 : mx;
            mt[k] = 1'b1;
          end
        end else begin
          mv[k] = ud ? mv[k] + 1 : mv[k] - 1;
          mt[k] = msat[k] && (mv[k] == tgt);
          ms[k] = mt[k];
        end
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.g[k] = 8'(mv[k] ^ (mv[k] >> 1));
      e.b[k] = 8'(mv[k]);
      e.t[k] = mt[k];
      e.s[k] = ms[k];
    end
    q.push_back(e);
  endtask

  task automatic step(bit en, bit ud, bit ld, logic [7:0] lg);
    @(negedge clk);
    enable = en; up_dn = ud; load = ld; load_gray = lg;
    model_step(en, ud, ld, int'(lg));
    push_exp();
  endtask

  // Reset is raised between edges so its effect is observed before any clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    enable = 1'b0; load = 1'b0;
    model_reset();
    push_exp();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk(string nm, logic [31:0] act, int exp);
    nvec++;
    if (act !== 32'(exp)) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      #1;
      while (q.size() > 0) begin
        exp_t e;
        logic [7:0] ag[3], ab[3];
        logic       at[3], as[3];
        e = q.pop_front();
        ag = '{8'(g0), 8'(g1), g2};
        ab = '{8'(b0), 8'(b1), b2};
        at = '{t0, t1, t2};
        as = '{s0, s1, s2};
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("u%0d gray", k), 32'(ag[k]), int'(e.g[k]));
          chk($sformatf("u%0d bin", k), 32'(ab[k]), int'(e.b[k]));
          chk($sformatf("u%0d tc", k), 32'(at[k]), int'(e.t[k]));
          chk($sformatf("u%0d sat", k), 32'(as[k]), int'(e.s[k]));
        end
`ifdef GRAY_CHECK_EN
        chk("u0 gray_err", 32'(e0), 0);
        chk("u1 gray_err", 32'(e1), 0);
        chk("u2 gray_err", 32'(e2), 0);
`endif
      end
    end
  end

  initial begin
    mig = '{int'(IG0), int'(IG1), int'(IG2)};
    model_reset();
    #3;
    do_reset();
    // Count up through the full 5-bit range and wrap; saturating copy pins at max.
    repeat (32) step(1'b1, 1'b1, 1'b0, 8'h00);
    // Down from zero wraps to max with tc.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    // Load gray 10001 (bin 30), climb into and hold at max, then reverse.
    step(1'b0, 1'b1, 1'b1, 8'h11);
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    // Load bin 7, then load bin 8 with enable also high.
    step(1'b0, 1'b1, 1'b1, 8'h04);
    step(1'b1, 1'b1, 1'b1, 8'h0C);
    // Load bin 20, reset between edges, then hold with enable low.
    step(1'b0, 1'b0, 1'b1, 8'h1E);
    do_reset();
    repeat (5) step(1'b0, 1'b1, 1'b0, 8'h00);
    // Load of zero on the saturating counter recomputes sat.
    step(1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 39) == 0, 8'($urandom));
    end
    repeat (3) @(negedge clk);
    nvec++;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised Gray-code counter; successor to the fixed 5-bit enable-only Gray counter.
- Adds:
  - configurable width
  - up/down counting
  - synchronous load of a Gray-coded value
  - wrap or saturate mode
  - terminal-count pulse
- All outputs registered. Used as a pointer/sequence source for clock-domain-crossing structures and verification stimulus.

Parameters:
WIDTH, 5, counter width in bits (>=2)
SATURATE, 0, 0 = wrap at ends; 1 = hold at terminal value
INIT_GRAY, 0, Gray value loaded on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
enable  input  1  count advance when high
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_gray  input  WIDTH  Gray-coded value to load
gray_output  output  WIDTH  registered Gray count
bin_output  output  WIDTH  registered binary equivalent of gray_output
tc  output  1  one-cycle terminal-count pulse
sat  output  1  high while held at a terminal value (SATURATE=1 only, else 0)

Behaviour:
- Internal state is a WIDTH-bit binary register `bin`.
- `gray_output` = bin ^ (bin >> 1), registered. Both outputs update on the same edge; no combinational path from inputs to outputs.
- Reset (async, high):
  - `bin` = gray-to-binary(INIT_GRAY)
  - `gray_output` = INIT_GRAY
  - `bin_output` = `bin`
  - `tc` = 0, `sat` = 0
- Priority each rising edge: reset > load > enable > hold.
- Load: `bin` <= gray-to-binary(load_gray), where binary bit i = XOR of gray bits WIDTH-1..i.
  - Load ignores `enable` and `up_dn`.
  - `tc` = 0 on the load edge.
  - `sat` is recomputed from the loaded value.
- Enable, up_dn=1:
  - If `bin` = 2^WIDTH-1:
    - SATURATE=0 → wrap to 0, `tc` = 1 for one cycle.
    - SATURATE=1 → hold, `sat` = 1, `tc` = 1 only on the cycle the max is first reached.
  - Otherwise `bin`+1.
- Enable, up_dn=0:
  - If `bin` = 0:
    - SATURATE=0 → wrap to 2^WIDTH-1, `tc` = 1.
    - SATURATE=1 → hold, `sat` = 1.
  - Otherwise `bin`-1.
- `tc` is asserted in the same cycle `gray_output` first shows the wrapped or terminal value; it is deasserted the following cycle unless another wrap occurs.
- Saturate mode:
  - `sat` clears on the first edge that moves `bin` off the terminal value (direction reversal or load).
  - `tc` is not re-pulsed while holding.
- Enable low: all state held, `tc` = 0.
- `up_dn` may change every cycle; successive outputs still differ by exactly one Gray bit (or zero when holding).
- Arithmetic is modulo 2^WIDTH; no X propagation from unused bits.
- Reset mid-count takes effect immediately, without waiting for a clock edge.

Optional Feature:
- Macro: `GRAY_CHECK_EN`.
- When defined:
  - Adds output port `gray_err` (1 bit, reset 0).
  - Internal register holds the previous `gray_output`.
  - `gray_err` goes high for one cycle if a non-load, non-reset update changes more than one bit of `gray_output`.
  - `gray_err` is sticky until reset if the `sat`/`tc` rules above are violated.
- When undefined: port and logic absent, behaviour otherwise identical.

Test Plan (WIDTH=5 unless stated):
1. Reset high, INIT_GRAY=0 → gray_output=00000, bin_output=0, tc=0. Release reset, enable=1, up_dn=1 for 31 cycles → gray_output steps 00001, 00011, 00010… and reaches 10000 at bin=31. Next edge → gray_output=00000 and tc=1 for one cycle.
2. From reset, up_dn=0, enable=1, SATURATE=0 → first edge gray_output=10000, bin_output=31, tc=1. Then 10001 (bin 30).
3. SATURATE=1, load_gray=10001 (bin 30), up_dn=1 → next edge bin 31 with tc=1 and sat=1. Further edges hold 10000 with tc=0. Set up_dn=0 → bin 30, sat=0.
4. Counting up at bin 7; assert load=1 with load_gray=01100 (bin 8) and enable=1 → next output 01100/8, tc=0. Load and enable together: load wins.
5. Assert reset asynchronously mid-cycle at bin 20 → outputs go to INIT_GRAY before the next clock edge. enable=0 for 5 cycles → outputs unchanged, tc=0.
6. WIDTH=8, random enable/up_dn for 2000 cycles, with GRAY_CHECK_EN defined → gray_err never asserts. Also check bin_output equals the reference model.
